key_event_gen: RTL and testbench

//   Consumer end of the debounced button path: takes clean key levels and emits discrete
//   key events for game control (e.g. Snake direction input).

---
 rtl/key_event_gen_if.sv | 28 ++
 rtl/key_event_gen.sv | 196 +++++++++++++++++++
 tb/tb_key_event_gen.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
`default_nettype none
// ============================================================================
// key_event_gen_if : valid/ready key-event channel (master = event producer)
// Rev 1.0
// ============================================================================
interface key_event_gen_if #(
  parameter int CODE_W = 2
) ();
  logic              event_valid;
  logic              event_ready;
  logic [CODE_W-1:0] event_code;
  logic              event_repeat;

  modport master (
    output event_valid,
    output event_code,
    output event_repeat,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_code,
    input  event_repeat,
    output event_ready
  );
endinterface
`default_nettype wire

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
// key_event_gen : debounced key levels -> press / typematic-repeat events
//                 (define KEY_REPEAT_EN to build the auto-repeat FSM)
// Rev 1.0
// ============================================================================
module key_event_gen #(
  parameter int NKEYS         = 4,
  parameter int CODE_W        = 2,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter int CNT_W         = 26
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [NKEYS-1:0]  key_level,
  key_event_gen_if.master        evt,
  output logic                   active_valid,
  output logic [CODE_W-1:0]      active_code,
  output logic                   overflow,
  input  wire logic              ovf_clear
);

  if (NKEYS < 2 || NKEYS > 16 || (2 ** CODE_W) < NKEYS ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || CNT_W < 1) begin : g_param_check
    $error("key_event_gen: illegal parameter combination");
  end

`ifdef KEY_REPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_evt_repeat;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NKEYS-1:0]  r_key_prev;
  logic              r_active_valid;
  logic [CODE_W-1:0] r_active_code;
  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_overflow;

  logic [NKEYS-1:0]  w_rise;
  logic              w_rise_any;
  logic [CODE_W-1:0] w_rise_code;
  logic              w_active_held;
  logic              w_active_valid_nxt;
  logic [CODE_W-1:0] w_active_code_nxt;
  logic              w_gen;
  logic [CODE_W-1:0] w_gen_code;
  logic              w_gen_repeat;
  logic              w_slot_free;
  logic              w_drop;

  assign w_rise        = key_level & ~r_key_prev;
  assign w_rise_any    = |w_rise;
  assign w_active_held = key_level[r_active_code];

  // Scan downwards so the lowest rising index is the one left standing.
  always_comb begin
    w_rise_code = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_rise_code = CODE_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_active_valid_nxt = r_active_valid;
    w_active_code_nxt  = r_active_code;
    w_gen              = 1'b0;
    w_gen_code         = r_active_code;
    w_gen_repeat       = 1'b0;
`ifdef KEY_REPEAT_EN
    w_cnt_nxt          = r_cnt;
`endif
    // A fresh press pre-empts both release handling and timer expiry.
    if (w_rise_any) begin
      w_gen              = 1'b1;
      w_gen_code         = w_rise_code;
      w_active_valid_nxt = 1'b1;
      w_active_code_nxt  = w_rise_code;
`ifdef KEY_REPEAT_EN
      w_state_nxt        = ST_DELAY;
      w_cnt_nxt          = '0;
`else
      w_state_nxt        = ST_HELD;
`endif
    end else begin
      case (r_state)
`ifdef KEY_REPEAT_EN
        ST_DELAY, ST_REPEAT: begin
          if (!w_active_held) begin
            w_state_nxt        = ST_IDLE;
            w_active_valid_nxt = 1'b0;
            w_cnt_nxt          = '0;
          end else if (r_cnt == ((r_state == ST_DELAY) ? c_delay_last : c_period_last)) begin
            w_gen        = 1'b1;
            w_gen_repeat = 1'b1;
            w_state_nxt  = ST_REPEAT;
            w_cnt_nxt    = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`else
        ST_HELD: begin
          if (!w_active_held) begin
            w_state_nxt        = ST_IDLE;
            w_active_valid_nxt = 1'b0;
          end
        end
`endif
        default: begin
          w_state_nxt        = ST_IDLE;
          w_active_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output slot is writable when empty or being consumed this cycle.
  assign w_slot_free = ~r_evt_valid | evt.event_ready;
  assign w_drop      = w_gen & ~w_slot_free;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_key_prev     <= '0;
      r_active_valid <= 1'b0;
      r_active_code  <= '0;
      r_evt_valid    <= 1'b0;
      r_evt_code     <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_key_prev     <= key_level;
      r_active_valid <= w_active_valid_nxt;
      r_active_code  <= w_active_code_nxt;
      if (w_slot_free) begin
        r_evt_valid <= w_gen;
        if (w_gen) begin
          r_evt_code <= w_gen_code;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_evt_repeat <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_slot_free && w_gen) begin
        r_evt_repeat <= w_gen_repeat;
      end
    end
  end

  assign evt.event_repeat = r_evt_repeat;
`else
  assign evt.event_repeat = w_gen_repeat;
`endif

  assign evt.event_valid = r_evt_valid;
  assign evt.event_code  = r_evt_code;
  assign active_valid    = r_active_valid;
  assign active_code     = r_active_code;
  assign overflow        = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
// tb_key_event_gen : directed self-checking bench for key_event_gen
// Rev 1.0
// ============================================================================
module tb_key_event_gen;

  logic       clk;
  logic       reset;
  logic [3:0] key_level;
  logic       active_valid;
  logic [1:0] active_code;
  logic       overflow;
  logic       ovf_clear;
  int         n_tests;
  int         n_fail;

  key_event_gen_if #(.CODE_W(2)) evt ();

  key_event_gen #(
    .NKEYS(4), .CODE_W(2), .REPEAT_DELAY(8), .REPEAT_PERIOD(3), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .key_level(key_level), .evt(evt),
    .active_valid(active_valid), .active_code(active_code),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, code[1:0], repeat, active_valid, active_code[1:0], overflow}
  function automatic logic [7:0] snap();
    return {evt.event_valid, evt.event_code, evt.event_repeat,
            active_valid, active_code, overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_level = 4'b0000; ovf_clear = 1'b0; evt.event_ready = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (snap() !== 8'b0) begin
      n_fail++; $display("FAIL reset_state: got %b want %b", snap(), 8'b0);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (snap() !== 8'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b want %b", snap(), 8'b0);
    end
  endtask

  task automatic test_single_press();
    key_level = 4'b0100;
    tick();
    n_tests++;
    if (snap() !== 8'b1_10_0_1_10_0) begin
      n_fail++; $display("FAIL single_press: got %b want %b", snap(), 8'b1_10_0_1_10_0);
    end
    key_level = 4'b0000;
    tick();
    n_tests++;
    if ({evt.event_valid, active_valid} !== 2'b00) begin
      n_fail++; $display("FAIL single_release: got %b want 00", {evt.event_valid, active_valid});
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_tests++;
      if (evt.event_valid !== 1'b0) begin
        n_fail++; $display("FAIL single_idle cyc %0d: got %b want 0", i, evt.event_valid);
      end
    end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_auto_repeat();
    logic exp_v;
    key_level = 4'b0010;
    for (int i = 1; i <= 24; i++) begin
      tick();
      exp_v = (i == 1) || (i == 9) || (i == 12) || (i == 15) || (i == 18);
      n_tests++;
      if ({evt.event_valid, active_valid} !== {exp_v, (i <= 20)}) begin
        n_fail++; $display("FAIL repeat_timing cyc %0d: got %b want %b",
                           i, {evt.event_valid, active_valid}, {exp_v, (i <= 20)});
      end
      if (exp_v) begin
        n_tests++;
        if ({evt.event_code, evt.event_repeat} !== {2'd1, (i != 1)}) begin
          n_fail++; $display("FAIL repeat_event cyc %0d: got %b want %b",
                             i, {evt.event_code, evt.event_repeat}, {2'd1, (i != 1)});
        end
      end
      if (i == 20) key_level = 4'b0000;
    end
  endtask
`else
  task automatic test_no_repeat();
    int n_ev;
    n_ev = 0;
    key_level = 4'b1000;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (evt.event_valid === 1'b1) begin
        n_ev++;
        n_tests++;
        if ({evt.event_code, evt.event_repeat} !== 3'b11_0) begin
          n_fail++; $display("FAIL hold_event cyc %0d: got %b want 110",
                             i, {evt.event_code, evt.event_repeat});
        end
      end
      if (i == 30) key_level = 4'b0000;
      if (i == 30 || i == 31) begin
        n_tests++;
        if (active_valid !== (i == 30)) begin
          n_fail++; $display("FAIL hold_active cyc %0d: got %b want %b", i, active_valid, (i == 30));
        end
      end
    end
    n_tests++;
    if (n_ev != 1) begin
      n_fail++; $display("FAIL hold_event_count: got %0d want 1", n_ev);
    end
  endtask
`endif

  task automatic test_priority();
    key_level = 4'b1001;
    tick();
    n_tests++;
    if (snap() !== 8'b1_00_0_1_00_0) begin
      n_fail++; $display("FAIL priority_press: got %b want %b", snap(), 8'b1_00_0_1_00_0);
    end
    tick();
    key_level = 4'b1000;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_tests++;
      if ({evt.event_valid, active_valid} !== 2'b00) begin
        n_fail++; $display("FAIL priority_silent cyc %0d: got %b want 00",
                           i, {evt.event_valid, active_valid});
      end
    end
    key_level = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    key_level = 4'b0010;
    tick();
    key_level = 4'b0110;
    tick();
    n_tests++;
    if (snap() !== 8'b1_10_0_1_10_0) begin
      n_fail++; $display("FAIL b2b_load: got %b want %b", snap(), 8'b1_10_0_1_10_0);
    end
    key_level = 4'b0000;
    tick();
    n_tests++;
    if (evt.event_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b want 0", evt.event_valid);
    end
    tick();
  endtask

  task automatic test_overflow();
    evt.event_ready = 1'b0;
    key_level = 4'b0010;
    tick();
    key_level = 4'b0110;
    tick();
    n_tests++;
    if (snap() !== 8'b1_01_0_1_10_1) begin
      n_fail++; $display("FAIL ovf_drop: got %b want %b", snap(), 8'b1_01_0_1_10_1);
    end
    key_level = 4'b0000; ovf_clear = 1'b1;
    tick();
    n_tests++;
    if ({evt.event_valid, evt.event_code, overflow} !== 4'b1_01_0) begin
      n_fail++; $display("FAIL ovf_clear: got %b want 1010",
                         {evt.event_valid, evt.event_code, overflow});
    end
    ovf_clear = 1'b0; evt.event_ready = 1'b1;
    tick();
    n_tests++;
    if (evt.event_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_accept: got %b want 0", evt.event_valid);
    end
    // Drop and clear in the same cycle: the drop must win.
    evt.event_ready = 1'b0; key_level = 4'b0001;
    tick();
    key_level = 4'b0011; ovf_clear = 1'b1;
    tick();
    n_tests++;
    if ({evt.event_code, overflow} !== 3'b00_1) begin
      n_fail++; $display("FAIL ovf_set_wins: got %b want 001", {evt.event_code, overflow});
    end
    key_level = 4'b0000;
    tick();
    ovf_clear = 1'b0; evt.event_ready = 1'b1;
    tick();
    n_tests++;
    if ({evt.event_valid, overflow} !== 2'b00) begin
      n_fail++; $display("FAIL ovf_final: got %b want 00", {evt.event_valid, overflow});
    end
  endtask

  task automatic test_reset_mid_hold();
    key_level = 4'b0001;
    tick();
    reset = 1'b1;
    tick();
    n_tests++;
    if (snap() !== 8'b0) begin
      n_fail++; $display("FAIL midhold_reset1: got %b want %b", snap(), 8'b0);
    end
    tick();
    n_tests++;
    if (snap() !== 8'b0) begin
      n_fail++; $display("FAIL midhold_reset2: got %b want %b", snap(), 8'b0);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (snap() !== 8'b1_00_0_1_00_0) begin
      n_fail++; $display("FAIL midhold_repress: got %b want %b", snap(), 8'b1_00_0_1_00_0);
    end
    key_level = 4'b0000;
    tick(); tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    reset = 1'b1; key_level = 4'b0000; ovf_clear = 1'b0; evt.event_ready = 1'b1;
    test_reset();
    test_single_press();
`ifdef KEY_REPEAT_EN
    test_auto_repeat();
`else
    test_no_repeat();
`endif
    test_priority();
    test_back_to_back();
    test_overflow();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
